// File: rtl/r_reg_p_if.sv
// Byte-path bundle between the router controller/FIFO side and the r_reg_p register block.
// The master side drives packet bytes and controller flags; the slave side returns the checked byte stream.
interface r_reg_p_if #(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 2,
  parameter int CNT_W      = 8
);
  localparam int HC_W = $clog2(HOLD_DEPTH + 1);

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              parity_done;
  logic              low_packet_valid;
  logic              err;
  logic              hold_ovf;
  logic [HC_W-1:0]   hold_count;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, dout_valid, parity_done, low_packet_valid, err, hold_ovf,
           hold_count, err_cnt
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, dout_valid, parity_done, low_packet_valid, err, hold_ovf,
           hold_count, err_cnt
  );
endinterface

// File: rtl/r_reg_p.sv
// Router register block: forwards header/payload bytes, buffers bytes arriving while the
// output FIFO is full, and checks each packet's parity/checksum and length.
module r_reg_p #(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 2,
  parameter int PAR_MODE   = 0,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  r_reg_p_if.slave    bus
);
  localparam int HC_W  = $clog2(HOLD_DEPTH + 1);
  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(HOLD_DEPTH - 1);
  localparam logic [HC_W-1:0]  HOLD_FULL = HC_W'(HOLD_DEPTH);
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;

  logic [DATA_W-1:0] header_reg, acc_reg, parity_reg, pay_cnt_reg, dout_reg;
  logic              par_cap_reg, dout_valid_reg, parity_done_reg, parity_done_q_reg;
  logic              low_pv_reg, err_reg, hold_ovf_reg;
  logic [HC_W-1:0]   hold_count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  err_cnt_reg;
  logic [DATA_W-1:0] hold_mem [HOLD_DEPTH];

  logic [DATA_W-1:0] acc_op;
  logic hold_empty, new_pkt, take_lfd, take_ld, take_laf, par_slot;
  logic push_req, push_ok, pop, pass, pd_rise, len_bad, chk_bad;

  generate
    if (PAR_MODE == 0) begin : g_xor
      assign acc_op = acc_reg ^ bus.data_in;
    end else begin : g_sum
      assign acc_op = acc_reg + bus.data_in;
    end
  endgenerate

  // Flag priority: detect_add > lfd_state > ld_state > laf_state; full_state freezes load/pop.
  assign new_pkt    = bus.detect_add && bus.pkt_valid;
  assign take_lfd   = !bus.detect_add && bus.lfd_state;
  assign take_ld    = !bus.detect_add && !bus.lfd_state && bus.ld_state && !bus.full_state;
  assign take_laf   = !bus.detect_add && !bus.lfd_state && !bus.ld_state
                      && bus.laf_state && !bus.full_state;
  assign hold_empty = (hold_count_reg == '0);
  assign par_slot   = take_ld && !bus.pkt_valid && !par_cap_reg;
  // A payload byte must queue behind anything already held to keep byte order.
  assign push_req   = take_ld && ((bus.pkt_valid && (bus.fifo_full || !hold_empty))
                                  || (par_slot && bus.fifo_full));
  assign push_ok    = push_req && (hold_count_reg != HOLD_FULL);
  assign pop        = take_laf && !bus.fifo_full && !hold_empty;
  assign pass       = take_ld && bus.pkt_valid && !bus.fifo_full && hold_empty;
  assign pd_rise    = parity_done_reg && !parity_done_q_reg;
  assign len_bad    = (pay_cnt_reg != {2'b00, header_reg[DATA_W-1:2]});
  assign chk_bad    = (acc_reg != parity_reg) || len_bad || hold_ovf_reg;

  always_ff @(posedge clk) begin
    if (push_ok) hold_mem[wr_ptr_reg] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      header_reg <= '0; acc_reg <= '0; parity_reg <= '0; pay_cnt_reg <= '0;
      dout_reg <= '0; dout_valid_reg <= 1'b0; par_cap_reg <= 1'b0;
      parity_done_reg <= 1'b0; parity_done_q_reg <= 1'b0; low_pv_reg <= 1'b0;
      err_reg <= 1'b0; hold_ovf_reg <= 1'b0; hold_count_reg <= '0;
      wr_ptr_reg <= '0; rd_ptr_reg <= '0; err_cnt_reg <= '0;
    end else begin
      dout_valid_reg    <= 1'b0;
      parity_done_q_reg <= parity_done_reg;
      if (bus.ld_state && !bus.pkt_valid) low_pv_reg <= 1'b1;
      else if (bus.rst_int_reg)           low_pv_reg <= 1'b0;

      if (new_pkt) begin
        header_reg <= bus.data_in; acc_reg <= '0; parity_reg <= '0; pay_cnt_reg <= '0;
        par_cap_reg <= 1'b0; parity_done_reg <= 1'b0; err_reg <= 1'b0;
        hold_ovf_reg <= 1'b0; hold_count_reg <= '0; wr_ptr_reg <= '0; rd_ptr_reg <= '0;
      end else begin
        if (take_lfd) begin
          dout_reg <= header_reg; dout_valid_reg <= 1'b1; acc_reg <= header_reg;
        end
        if (take_ld && bus.pkt_valid) begin
          acc_reg <= acc_op;
          if (pay_cnt_reg != '1) pay_cnt_reg <= pay_cnt_reg + DATA_W'(1);
        end
        if (pass) begin
          dout_reg <= bus.data_in; dout_valid_reg <= 1'b1;
        end
        if (par_slot) begin
          parity_reg <= bus.data_in; par_cap_reg <= 1'b1;
        end
        if (push_ok) begin
          wr_ptr_reg     <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
          hold_count_reg <= hold_count_reg + HC_W'(1);
        end
        if (push_req && !push_ok) hold_ovf_reg <= 1'b1;
        if (pop) begin
          dout_reg       <= hold_mem[rd_ptr_reg]; dout_valid_reg <= 1'b1;
          rd_ptr_reg     <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
          hold_count_reg <= hold_count_reg - HC_W'(1);
        end
        if (par_cap_reg && hold_empty) parity_done_reg <= 1'b1;
        // Verdict is taken once, on the cycle after parity_done first rises.
        if (pd_rise && chk_bad) begin
          err_reg <= 1'b1;
          if (!err_reg && err_cnt_reg != ERR_MAX) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.dout             = dout_reg;
  assign bus.dout_valid       = dout_valid_reg;
  assign bus.parity_done      = parity_done_reg;
  assign bus.low_packet_valid = low_pv_reg;
  assign bus.err              = err_reg;
  assign bus.hold_ovf         = hold_ovf_reg;
  assign bus.hold_count       = hold_count_reg;
  assign bus.err_cnt          = err_cnt_reg;
endmodule

// File: tb/tb_r_reg_p.sv
// Bench for r_reg_p: XOR and checksum instances share stimulus; delivered bytes are
// scoreboarded and per-packet err/parity_done/hold status compared against expectations.
module tb_r_reg_p;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0, fifo_full = 1'b0, detect_add = 1'b0, lfd_state = 1'b0;
  logic       ld_state = 1'b0, laf_state = 1'b0, full_state = 1'b0, rst_int_reg = 1'b0;
  logic [7:0] data_in = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] hold_m[$];

  always #5 clk = ~clk;

  r_reg_p_if #(.DATA_W(8), .HOLD_DEPTH(2), .CNT_W(8)) bus0 ();
  r_reg_p_if #(.DATA_W(8), .HOLD_DEPTH(2), .CNT_W(8)) bus1 ();

  assign bus0.pkt_valid = pkt_valid;   assign bus1.pkt_valid = pkt_valid;
  assign bus0.data_in = data_in;       assign bus1.data_in = data_in;
  assign bus0.fifo_full = fifo_full;   assign bus1.fifo_full = fifo_full;
  assign bus0.detect_add = detect_add; assign bus1.detect_add = detect_add;
  assign bus0.lfd_state = lfd_state;   assign bus1.lfd_state = lfd_state;
  assign bus0.ld_state = ld_state;     assign bus1.ld_state = ld_state;
  assign bus0.laf_state = laf_state;   assign bus1.laf_state = laf_state;
  assign bus0.full_state = full_state; assign bus1.full_state = full_state;
  assign bus0.rst_int_reg = rst_int_reg; assign bus1.rst_int_reg = rst_int_reg;

  r_reg_p #(.DATA_W(8), .HOLD_DEPTH(2), .PAR_MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  r_reg_p #(.DATA_W(8), .HOLD_DEPTH(2), .PAR_MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    sb0.push_back(b);
    sb1.push_back(b);
  endtask

  always @(negedge clk) begin
    if (bus0.dout_valid === 1'b1) begin
      if (sb0.size() == 0) check_val("dout0_unexpected", 32'(bus0.dout_valid), 32'd0);
      else check_val("dout0", 32'(bus0.dout), 32'(sb0.pop_front()));
    end
    if (bus1.dout_valid === 1'b1) begin
      if (sb1.size() == 0) check_val("dout1_unexpected", 32'(bus1.dout_valid), 32'd0);
      else check_val("dout1", 32'(bus1.dout), 32'(sb1.pop_front()));
    end
  end

  task automatic idle();
    pkt_valid = 1'b0; fifo_full = 1'b0; detect_add = 1'b0; lfd_state = 1'b0;
    ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] hdr, input logic [7:0] pl [4],
                         input int n, input logic [7:0] par, input logic [3:0] full_mask,
                         input bit e0, input bit e1);
    bit ovf = 1'b0;
    bit popped;
    int k = 0;
    idle();
    hold_m.delete();
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
    @(negedge clk);
    detect_add = 1'b0; lfd_state = 1'b1; data_in = 8'h00;
    expect_byte(hdr);
    @(negedge clk);
    lfd_state = 1'b0; ld_state = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = pl[i]; fifo_full = full_mask[i];
      if (!full_mask[i] && hold_m.size() == 0) expect_byte(pl[i]);
      else if (hold_m.size() < 2) hold_m.push_back(pl[i]);
      else ovf = 1'b1;
      @(negedge clk);
    end
    check_val($sformatf("%s_hold_cnt", tag), 32'(bus0.hold_count), 32'(hold_m.size()));
    pkt_valid = 1'b0; data_in = par; fifo_full = 1'b0;
    @(negedge clk);
    check_val($sformatf("%s_pd_early", tag), 32'(bus0.parity_done), 32'd0);
    check_val($sformatf("%s_lpv_set", tag), 32'(bus0.low_packet_valid), 32'd1);
    ld_state = 1'b0; rst_int_reg = 1'b1; data_in = 8'h00;
    @(negedge clk);
    rst_int_reg = 1'b0;
    check_val($sformatf("%s_lpv_clr", tag), 32'(bus0.low_packet_valid), 32'd0);
    while (bus0.parity_done !== 1'b1 && k < 20) begin
      popped = 1'b0;
      if (hold_m.size() > 0) begin
        laf_state = 1'b1; popped = 1'b1;
        expect_byte(hold_m.pop_front());
      end else begin
        laf_state = 1'b0;
      end
      @(negedge clk);
      k++;
      if (popped)
        check_val($sformatf("%s_hold_pop", tag), 32'(bus0.hold_count), 32'(hold_m.size()));
    end
    laf_state = 1'b0;
    check_val($sformatf("%s_pd_seen", tag), 32'(bus0.parity_done), 32'd1);
    check_val($sformatf("%s_pd_hold0", tag), 32'(bus0.hold_count), 32'd0);
    check_val($sformatf("%s_err_early", tag), 32'(bus0.err), 32'd0);
    @(negedge clk);
    check_val($sformatf("%s_err0", tag), 32'(bus0.err), 32'(e0));
    check_val($sformatf("%s_err1", tag), 32'(bus1.err), 32'(e1));
    if (e0) exp_cnt0++;
    if (e1) exp_cnt1++;
    @(negedge clk);
    @(negedge clk);
    check_val($sformatf("%s_err0_held", tag), 32'(bus0.err), 32'(e0));
    check_val($sformatf("%s_cnt0", tag), 32'(bus0.err_cnt), 32'(exp_cnt0));
    check_val($sformatf("%s_cnt1", tag), 32'(bus1.err_cnt), 32'(exp_cnt1));
    check_val($sformatf("%s_ovf0", tag), 32'(bus0.hold_ovf), 32'(ovf));
    check_val($sformatf("%s_ovf1", tag), 32'(bus1.hold_ovf), 32'(ovf));
    check_val($sformatf("%s_pd1", tag), 32'(bus1.parity_done), 32'd1);
    check_val($sformatf("%s_sb_drained", tag), 32'(sb0.size()), 32'd0);
    $display("pkt %s hdr=%02h par=%02h err0=%0d err1=%0d err_cnt0=%0d hold_ovf=%0d",
             tag, hdr, par, bus0.err, bus1.err, bus0.err_cnt, bus0.hold_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_dout", 32'(bus0.dout), 32'd0);
    check_val("rst_dout_valid", 32'(bus0.dout_valid), 32'd0);
    check_val("rst_hold_count", 32'(bus0.hold_count), 32'd0);
    check_val("rst_err_cnt", 32'(bus0.err_cnt), 32'd0);
    check_val("rst_pd", 32'(bus0.parity_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_pkt("xor_ok",   8'h0C, '{8'h11, 8'h22, 8'h33, 8'h00}, 3, 8'h0C, 4'b0000, 1'b0, 1'b1);
    run_pkt("xor_bad",  8'h0C, '{8'h11, 8'h22, 8'h33, 8'h00}, 3, 8'h00, 4'b0000, 1'b1, 1'b1);
    run_pkt("sum_ok",   8'h08, '{8'hF0, 8'h20, 8'h00, 8'h00}, 2, 8'h18, 4'b0000, 1'b1, 1'b0);
    run_pkt("hold_2",   8'h08, '{8'h5A, 8'hA5, 8'h00, 8'h00}, 2, 8'hF7, 4'b0011, 1'b0, 1'b1);
    run_pkt("hold_ovf", 8'h0C, '{8'h01, 8'h02, 8'h04, 8'h00}, 3, 8'h0B, 4'b0111, 1'b1, 1'b1);
    run_pkt("len_bad",  8'h10, '{8'h10, 8'h20, 8'h30, 8'h00}, 3, 8'h10, 4'b0000, 1'b1, 1'b1);

    // Abort a packet with reset after its first payload byte.
    idle();
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h10;
    @(negedge clk);
    detect_add = 1'b0; lfd_state = 1'b1; expect_byte(8'h10);
    @(negedge clk);
    lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'hAA; expect_byte(8'hAA);
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_dout", 32'(bus0.dout), 32'd0);
    check_val("abort_dout_valid", 32'(bus0.dout_valid), 32'd0);
    check_val("abort_pd", 32'(bus0.parity_done), 32'd0);
    check_val("abort_lpv", 32'(bus0.low_packet_valid), 32'd0);
    check_val("abort_err", 32'(bus0.err), 32'd0);
    check_val("abort_ovf", 32'(bus0.hold_ovf), 32'd0);
    check_val("abort_hold", 32'(bus0.hold_count), 32'd0);
    check_val("abort_err_cnt", 32'(bus0.err_cnt), 32'd0);
    check_val("abort_err_cnt1", 32'(bus1.err_cnt), 32'd0);
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    repeat (3) @(negedge clk);
    check_val("abort_err_after", 32'(bus0.err), 32'd0);
    $display("pkt abort reset err=%0d err_cnt=%0d", bus0.err, bus0.err_cnt);

    run_pkt("post_rst", 8'h04, '{8'h7E, 8'h00, 8'h00, 8'h00}, 1, 8'h7A, 4'b0000, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check_val("final_sb1", 32'(sb1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/r_reg_p.md
R_REG_P -- requirements
Module: r_reg_p

Interface
REQ-001 Parameter DATA_W, default 8, data byte width in bits (>=4).
REQ-002 Parameter HOLD_DEPTH, default 2, hold buffer entries for bytes arriving while fifo_full (1..8).
REQ-003 Parameter PAR_MODE, default 0, check mode: 0 = XOR parity; 1 = additive checksum mod 2^DATA_W.
REQ-004 Parameter CNT_W, default 8, error counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pkt_valid  in  1  packet byte valid from source.
REQ-008 data_in  in  DATA_W  incoming header/payload/parity byte.
REQ-009 fifo_full  in  1  selected output FIFO full.
REQ-010 detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  controller state flags.
REQ-011 rst_int_reg  in  1  clears low_packet_valid.
REQ-012 dout  out  DATA_W  byte to output FIFO.
REQ-013 dout_valid  out  1  dout carries a new byte this cycle.
REQ-014 parity_done  out  1  packet check byte captured and all bytes delivered.
REQ-015 low_packet_valid  out  1  pkt_valid has fallen in load.
REQ-016 err  out  1  check mismatch or length mismatch for current packet.
REQ-017 hold_ovf  out  1  sticky: hold buffer overflowed this packet.
REQ-018 hold_count  out  $clog2(HOLD_DEPTH+1)  hold buffer occupancy.
REQ-019 err_cnt  out  CNT_W  saturating count of errored packets.

Function
REQ-020 Flag priority per cycle: detect_add > lfd_state > ld_state > laf_state; lower flags ignored when a higher one is set.
REQ-021 detect_add && pkt_valid: header_reg <= data_in; accumulator, packet_parity, payload counter, parity_done, err, hold_ovf cleared; hold buffer flushed.
REQ-022 lfd_state: dout <= header_reg, dout_valid = 1 next cycle; accumulator <= header_reg.
REQ-023 Accumulate op: PAR_MODE 0 acc ^ byte; PAR_MODE 1 (acc + byte) truncated to DATA_W bits.
REQ-024 ld_state && pkt_valid: byte accumulated and payload counter incremented regardless of fifo_full.
REQ-025 ld_state && pkt_valid && !fifo_full && hold buffer empty: dout <= data_in, dout_valid = 1 next cycle.
REQ-026 ld_state && fifo_full: data_in pushed into hold buffer; push when hold_count == HOLD_DEPTH drops the byte and sets hold_ovf.
REQ-027 First ld_state cycle with !pkt_valid: packet_parity <= data_in (once per packet); if fifo_full, also handled per REQ-026.
REQ-028 laf_state && !fifo_full && hold_count > 0: pop oldest entry to dout, dout_valid = 1 next cycle; one pop per cycle, FIFO order.
REQ-029 dout holds last value when dout_valid = 0.
REQ-030 parity_done set one cycle after packet_parity captured and hold_count == 0; cleared only by detect_add or reset.
REQ-031 Expected payload length = header_reg[DATA_W-1:2]; length mismatch = payload counter != expected at parity_done rise.
REQ-032 err set cycle after parity_done rises if accumulator != packet_parity, length mismatch, or hold_ovf; held until detect_add.
REQ-033 err_cnt increments once per err rising edge; saturates at 2^CNT_W-1.
REQ-034 low_packet_valid set on ld_state && !pkt_valid; else cleared on rst_int_reg; set wins if both.
REQ-035 full_state: no accumulation, no dout update; hold buffer retained.

Reset
REQ-036 reset = 1 at clk edge: dout = 0, dout_valid = 0, parity_done = 0, low_packet_valid = 0, err = 0, hold_ovf = 0, hold_count = 0, err_cnt = 0; header_reg, accumulator, packet_parity, counter cleared.
REQ-037 reset mid-packet aborts it; no output byte or err produced for that packet; next detect_add starts cleanly.

Verification
REQ-038 XOR, header 0x0C (len 3), payload 0x11,0x22,0x33, parity 0x0C^0x11^0x22^0x33=0x0C, no fifo_full -> dout 0x0C,0x11,0x22,0x33; parity_done=1, err=0.
REQ-039 Same packet, parity 0x00 -> err=1 cycle after parity_done, err_cnt=1.
REQ-040 PAR_MODE 1, header 0x08 (len 2), payload 0xF0,0x20, checksum 0x18 -> err=0.
REQ-041 fifo_full during 2 payload bytes, HOLD_DEPTH 2 -> hold_count=2, laf pops in order, parity_done after hold_count=0, err=0.
REQ-042 fifo_full during 3 bytes, HOLD_DEPTH 2 -> hold_ovf=1, third byte dropped, err=1.
REQ-043 Header len 4, 3 payload bytes, correct parity -> err=1 (length); reset mid-payload -> all outputs 0, err_cnt=0.
